// File: rtl/adc_avg_pkg.sv
// Shared constants and helpers for the adc_avg moving-average filter.
package adc_avg_pkg;

   // Legal range for the log2 window length.
   localparam int unsigned LOG2_N_MIN = 1;
   localparam int unsigned LOG2_N_MAX = 5;

   // Running-sum width: N full-scale samples fit without overflow.
   function automatic int unsigned sum_width(input int unsigned data_w,
                                             input int unsigned log2_n);
      return data_w + log2_n;
   endfunction

endpackage

// File: rtl/adc_avg_if.sv
// Sample-in / mean-out bundle for the adc_avg filter.
interface adc_avg_if #(
   parameter int unsigned DATA_W = 8
);
   logic              clear;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              full;

   // Producer side (ADC master / testbench).
   modport master (
      output clear, in_valid, in_data,
      input  out_valid, out_data, full
   );

   // Filter side.
   modport slave (
      input  clear, in_valid, in_data,
      output out_valid, out_data, full
   );
endinterface

// File: rtl/adc_avg_buf.sv
// N-entry circular sample buffer; rdata is the entry about to be overwritten.
module adc_avg_buf #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LOG2_N = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned N = 1 << LOG2_N;

   logic [DATA_W-1:0] mem_q [N];
   logic [LOG2_N-1:0] wr_ptr_q;

   // Oldest sample, read before this cycle's write lands.
   assign rdata = mem_q[wr_ptr_q];

   // Storage and write pointer; pointer wraps naturally at N since N is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
      end else if (we) begin
         mem_q[wr_ptr_q] <= wdata;
         wr_ptr_q        <= wr_ptr_q + LOG2_N'(1);
      end
   end

endmodule

// File: rtl/adc_avg.sv
// Boxcar moving-average filter: rounded mean of the last 2^LOG2_N samples.
module adc_avg
   import adc_avg_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LOG2_N = 3   // legal range LOG2_N_MIN..LOG2_N_MAX
) (
   input logic       clk,
   input logic       rst,
   adc_avg_if.slave  bus
);
   localparam int unsigned N     = 1 << LOG2_N;
   localparam int unsigned SUM_W = sum_width(DATA_W, LOG2_N);
   localparam int unsigned CNT_W = LOG2_N + 1;

   logic              accept;
   logic [DATA_W-1:0] old_data;
   logic [SUM_W-1:0]  sum_nxt;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   adc_avg_buf #(
      .DATA_W (DATA_W),
      .LOG2_N (LOG2_N)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.clear),
      .we    (accept),
      .wdata (bus.in_data),
      .rdata (old_data)
   );

   // Next-state for sum, fill count and output registers; clear beats in_valid.
   always_comb begin
      accept      = bus.in_valid & ~bus.clear;
      // Modular add/sub in full width; the true result is always non-negative.
      sum_nxt     = sum_q + SUM_W'(bus.in_data) - SUM_W'(old_data);
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      out_valid_d = accept;
      out_data_d  = out_data_q;
      if (bus.clear) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         sum_d = sum_nxt;
         if (cnt_q != CNT_W'(N)) cnt_d = cnt_q + CNT_W'(1);
         // Round half up; the mean never exceeds full scale.
         out_data_d = DATA_W'((sum_nxt + SUM_W'(N / 2)) >> LOG2_N);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   // Derived from cnt_q so it moves on the same edge as out_valid.
   assign bus.full      = (cnt_q == CNT_W'(N));

endmodule

// File: tb/tb_adc_avg.sv
// Directed testbench for adc_avg (DATA_W=8, LOG2_N=3).
module tb_adc_avg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   adc_avg_if #(.DATA_W(8)) bus ();

   adc_avg #(
      .DATA_W (8),
      .LOG2_N (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One spaced sample: pulse in_valid, check the result pulse and that it lasts one cycle.
   task automatic send(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_full,
                       input string tag);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, ".valid"}, bus.out_valid, 1);
      chk({tag, ".data"}, bus.out_data, exp_d);
      chk({tag, ".full"}, bus.full, exp_full);
      @(negedge clk);
      chk({tag, ".pulse_end"}, bus.out_valid, 0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clear.full", bus.full, 0);
   endtask

   logic [7:0] fs_tbl [8];
   logic [7:0] one_tbl [8];

   initial begin
      fs_tbl  = '{8'h20, 8'h40, 8'h60, 8'h80, 8'h9F, 8'hBF, 8'hDF, 8'hFF};
      one_tbl = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst.valid", bus.out_valid, 0);
      chk("rst.data", bus.out_data, 0);
      chk("rst.full", bus.full, 0);
      rst = 1'b0;

      // Ramp-up: 8 x 0x40, 5 cycles apart
      for (int k = 1; k <= 8; k++) begin
         send(8'h40, 8'(8 * k), (k == 8), $sformatf("ramp%0d", k));
         repeat (3) @(negedge clk);
      end

      // Clear collides with a sample: sample dropped, out_data held
      @(negedge clk);
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40;
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      chk("coll.valid", bus.out_valid, 0);
      chk("coll.full", bus.full, 0);
      chk("coll.data", bus.out_data, 8'h40);
      send(8'h40, 8'h08, 1'b0, "coll.next");

      // Full scale, 16 back-to-back samples from an empty window
      do_clear();
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i == 0) chk("fs.idle", bus.out_valid, 0);
         else begin
            chk($sformatf("fs%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("fs%0d.data", i), bus.out_data, (i >= 8) ? 8'hFF : fs_tbl[i-1]);
            chk($sformatf("fs%0d.full", i), bus.full, (i >= 8));
         end
         bus.in_valid = (i < 16);
         bus.in_data  = 8'hFF;
      end
      @(negedge clk);
      chk("fs.after", bus.out_valid, 0);

      // Step and wrap: full window of zeros, then 0x80 x8, then one 0x00
      do_clear();
      for (int k = 1; k <= 8; k++) send(8'h00, 8'h00, (k == 8), $sformatf("zero%0d", k));
      for (int k = 1; k <= 8; k++) send(8'h80, 8'(16 * k), 1'b1, $sformatf("step%0d", k));
      send(8'h00, 8'h70, 1'b1, "wrap");

      // Reset asserted between edges during back-to-back traffic
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40;
      repeat (2) @(negedge clk);
      chk("rmid.pre_valid", bus.out_valid, 1);
      chk("rmid.pre_full", bus.full, 1);
      #2 rst = 1'b1;
      #1;
      chk("rmid.valid", bus.out_valid, 0);
      chk("rmid.data", bus.out_data, 0);
      chk("rmid.full", bus.full, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b0;
      send(8'h40, 8'h08, 1'b0, "rmid.after");

      // Rounding
      do_clear();
      send(8'h04, 8'h01, 1'b0, "rnd.04");
      do_clear();
      send(8'h03, 8'h00, 1'b0, "rnd.03");
      do_clear();
      for (int k = 1; k <= 8; k++) send(8'h01, one_tbl[k-1], (k == 8), $sformatf("rnd1_%0d", k));
      send(8'h05, 8'h02, 1'b1, "rnd.05");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_avg.md
# adc_avg

Moving-average (boxcar) filter for the 8-bit ADC sample stream. It sits between the SPI ADC master and the consumers of `adc_data` (UART string formatter, 7-segment display). It accepts one sample per end-of-conversion pulse and emits the rounded mean of the last 2^LOG2_N samples one cycle later. A `full` flag marks when the window holds real data.

## Interface
- `DATA_W`, default 8: sample and output width.
- `LOG2_N`, default 3: log2 of window length N (N = 8 by default); legal range 1..5.

- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush of window, sum and fill count.
- `in_valid`  in  1  one-cycle pulse, new sample present (driven from end of ADC conversion).
- `in_data`  in  DATA_W  ADC sample, sampled when `in_valid`=1.
- `out_valid`  out  1  one-cycle pulse, `out_data` updated.
- `out_data`  out  DATA_W  rounded window mean, held between pulses.
- `full`  out  1  window has received at least N samples since reset/clear.

## Operation
- Storage: N-entry register array `buf`, write pointer `wr_ptr` (LOG2_N bits), running sum `sum` (DATA_W+LOG2_N bits), fill counter `cnt` (LOG2_N+1 bits, saturates at N).
- On `in_valid`=1 and `clear`=0:
  - `old` = `buf[wr_ptr]`.
  - Write `in_data` to `buf[wr_ptr]`.
  - `sum_nxt` = `sum` + `in_data` − `old`, computed in full width. Never overflows, because max sum = N·(2^DATA_W−1).
  - `wr_ptr` increments and wraps N−1 → 0.
  - `cnt` increments, saturating at N.
- Output arithmetic: `out_data` = (`sum_nxt` + N/2) >> LOG2_N, i.e. round-half-up. The result cannot exceed 2^DATA_W−1, so no saturation logic is needed.
- Before the window fills, empty slots count as zero. The output ramps up; consumers gate on `full` if they need settled values.
- `full` = (`cnt` == N). It rises with the output pulse of the N-th sample.
- `clear`=1 has priority over `in_valid`:
  - `buf`, `sum`, `wr_ptr` and `cnt` go to 0 on the next edge.
  - A coincident sample is discarded and `out_valid` stays 0.
  - `out_data` holds its last value; `full` drops to 0.
- `in_valid` with no change in mean still pulses `out_valid`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `full`=0; internally `buf`=0, `sum`=0, `wr_ptr`=0, `cnt`=0.
- Latency: `in_valid` at edge t gives `out_valid`=1 and the new `out_data` during cycle t+1. `out_valid` is asserted for exactly one cycle per accepted sample.
- Throughput: one sample per clock. Back-to-back `in_valid` is fully supported with no stall and no ready signal.
- `full` changes on the same edge as the `out_valid` it belongs to.
- Asserting `rst` mid-stream forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion must be synchronized by the top-level reset logic.
- `clear` takes effect at the next edge after it is sampled high. The first sample after `clear` is treated as sample 1 of a fresh window.

## Structure
- Shared package: window-length limits (LOG2_N min 1, max 5) and the derived width function for `sum` (DATA_W+LOG2_N). No typedefs required.
- One sub-module is natural: `adc_avg_buf`, the N-entry circular buffer.
  - Inputs: `clk`, `rst`, `clear`, `we`, `wdata`.
  - Outputs: `rdata` = `buf[wr_ptr]` combinationally, before the write.
  - Owns `wr_ptr` and its wrap.
- The top level holds `sum`, `cnt`, rounding and the output registers.

## Test plan
- **Ramp-up:** reset, then 8 pulses of 0x40 spaced 5 cycles apart.
  - `out_data` = 0x08, 0x10, 0x18, 0x20, 0x28, 0x30, 0x38, 0x40.
  - `full` rises with the 8th `out_valid`.
- **Full scale, no overflow:** 16 back-to-back samples of 0xFF. Outputs reach 0xFF at sample 8 and stay 0xFF with no wrap; `out_valid` is high for 16 consecutive cycles, starting one cycle after the first `in_valid`.
- **Step and wrap:** from a full window of 0x00, feed 0x80 eight times.
  - Outputs are 0x10, 0x20, … 0x80.
  - A 9th sample of 0x00 gives 0x70, which shows the oldest entry is evicted after `wr_ptr` wraps.
- **Rounding:** after reset, single sample 0x04 → `out_data`=0x01, and 0x03 → 0x00. With a full window of 0x01 plus one 0x05 replacing the oldest, sum=12 → `out_data`=0x02.
- **Clear collision:** `clear` and `in_valid` (0x40) in the same cycle.
  - No `out_valid`, `full`=0, `out_data` holds its previous value.
  - Next sample 0x40 → `out_data`=0x08.
- **Reset mid-stream:** assert `rst` between edges during back-to-back traffic. `out_valid`, `out_data` and `full` go to 0 without waiting for an edge; after release the first sample 0x40 gives 0x08.
